// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared FSM encoding and port indices for mem_arbiter
package mem_arbiter_pkg;

    // Lock ownership state: IDLE means no burst lock is held.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    // Values stored in the 1-bit last-granted pointer.
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/mem_arbiter_mem.sv
// rtl/mem_arbiter_mem.sv - single-port synchronous memory with registered read output
//
// Ports:
//   i_clk    clock, rising edge
//   i_en     access enable (one access per cycle)
//   i_we     1 = write, 0 = read (only meaningful with i_en)
//   i_addr   word address
//   i_wdata  write data
//   o_rdata  registered read data; updates only on an enabled read
module mem_arbiter_mem #(
    parameter int    ADDR_WIDTH = 6,
    parameter int    DATA_WIDTH = 16,
    parameter string FILE_NAME  = "mem_init.mif"
) (
    input  logic                  i_clk,
    input  logic                  i_en,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // FILE_NAME is consumed by the memory build flow that preloads the array;
    // an empty name means the array powers up with undefined contents.
    if (FILE_NAME == "") begin : g_no_init_file
    end

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] r_rdata;

    // No reset: contents and the output register survive rst_n. The output
    // register only moves on reads so the shared rdata bus holds between
    // rvalids. A single port never reads and writes in the same cycle, so a
    // read always observes every earlier write (write-first behaviour).
    always_ff @(posedge i_clk) begin
        if (i_en && i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_en && !i_we) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter with burst lock in front of one memory
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req0/req1           access request per port
//   lock0/lock1         burst lock, honoured only while that port holds the grant
//   we0/we1             1 = write, 0 = read
//   addr0/addr1         word address per port
//   wdata0/wdata1       write data per port
//   gnt0/gnt1           combinational grant; access completes at the next edge
//   rvalid0/rvalid1     registered; shared rdata belongs to that port this cycle
//   rdata               shared memory read data
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int    ADDR_WIDTH = 6,
    parameter int    DATA_WIDTH = 16,
    parameter string FILE_NAME  = "mem_init.mif"
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  lock0,
    input  logic                  lock1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata
);

    state_t r_state;
    state_t w_next_state;
    logic   r_last;
    logic   r_rvalid0;
    logic   r_rvalid1;

    logic   w_arb0;
    logic   w_arb1;
    logic   w_gnt0;
    logic   w_gnt1;

    logic                  w_mem_en;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;

    // Plain round-robin: on contention the port that was not served last wins.
    always_comb begin
        w_arb0 = 1'b0;
        w_arb1 = 1'b0;
        if (req0 && req1) begin
            if (r_last == PORT1) begin
                w_arb0 = 1'b1;
            end else begin
                w_arb1 = 1'b1;
            end
        end else if (req0) begin
            w_arb0 = 1'b1;
        end else if (req1) begin
            w_arb1 = 1'b1;
        end
    end

    always_comb begin
        w_gnt0       = 1'b0;
        w_gnt1       = 1'b0;
        w_next_state = ST_IDLE;

        case (r_state)
            // The lock owner wins outright while it keeps requesting; once it
            // stops, the other port may be served in the same cycle.
            ST_OWN0: begin
                if (req0) begin
                    w_gnt0 = 1'b1;
                end else begin
                    w_gnt1 = w_arb1;
                end
            end
            ST_OWN1: begin
                if (req1) begin
                    w_gnt1 = 1'b1;
                end else begin
                    w_gnt0 = w_arb0;
                end
            end
            default: begin
                w_gnt0 = w_arb0;
                w_gnt1 = w_arb1;
            end
        endcase

        // Grants are combinational, so they must be masked while reset is held.
        if (!rst_n) begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end

        // Only the port actually granted can take or keep the lock; a lock
        // from the losing port is ignored. Dropping req or lock returns to IDLE.
        if (w_gnt0 && lock0) begin
            w_next_state = ST_OWN0;
        end else if (w_gnt1 && lock1) begin
            w_next_state = ST_OWN1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_last    <= PORT1;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            if (w_gnt0) begin
                r_last <= PORT0;
            end else if (w_gnt1) begin
                r_last <= PORT1;
            end
            r_rvalid0 <= w_gnt0 && !we0;
            r_rvalid1 <= w_gnt1 && !we1;
        end
    end

    assign w_mem_en    = w_gnt0 | w_gnt1;
    assign w_mem_we    = (w_gnt0 & we0) | (w_gnt1 & we1);
    assign w_mem_addr  = w_gnt1 ? addr1  : addr0;
    assign w_mem_wdata = w_gnt1 ? wdata1 : wdata0;

    mem_arbiter_mem #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .FILE_NAME  (FILE_NAME)
    ) u_mem (
        .i_clk   (clk),
        .i_en    (w_mem_en),
        .i_we    (w_mem_we),
        .i_addr  (w_mem_addr),
        .i_wdata (w_mem_wdata),
        .o_rdata (rdata)
    );

    assign gnt0    = w_gnt0;
    assign gnt1    = w_gnt1;
    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6, memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, memory word width.
REQ-003 SHALL have parameter FILE_NAME, default "mem_init.mif", passed unchanged to the memory instance.
REQ-004 Ports (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0, req1  in  1  access request from port 0 / port 1.
- lock0, lock1  in  1  burst lock; sampled only while the same port holds the grant.
- we0, we1  in  1  1 = write, 0 = read.
- addr0, addr1  in  ADDR_WIDTH  word address.
- wdata0, wdata1  in  DATA_WIDTH  write data.
- gnt0, gnt1  out  1  combinational grant; access completes at the next rising edge.
- rvalid0, rvalid1  out  1  registered; rdata is valid for that port.
- rdata  out  DATA_WIDTH  shared read data, memory output.

Function
REQ-005 SHALL instantiate one single-port synchronous memory: one access per cycle, write-first, registered output.
REQ-006 At most one of gnt0/gnt1 SHALL be high in any cycle; a grant SHALL be issued only to a requesting port.
REQ-007 Arbitration SHALL be round-robin using a 1-bit last-granted pointer LAST:
- When both ports request, the port not equal to LAST wins.
- When one port requests, that port wins.
REQ-008 The FSM SHALL have states IDLE, OWN0 and OWN1.
- IDLE: no lock held; arbitration follows REQ-007.
- Granted port with lock=1 at the edge: next state OWNn.
- OWNn: port n wins whenever reqn=1, regardless of the other request.
- OWNn -> IDLE at the edge where reqn=0 or lockn=0.
- A lock asserted by a non-granted port SHALL be ignored.
REQ-009 LAST SHALL update to the granted port at every edge where a grant is issued, and SHALL hold otherwise.
REQ-010 Memory we/addr/data SHALL be muxed from the granted port.
- Memory we SHALL be 0 when no grant is issued.
REQ-011 A granted read at edge N SHALL raise rvalidn for exactly the cycle after N.
- rdata SHALL equal mem[addr] during that cycle.
REQ-012 A granted write SHALL update memory at edge N.
- A write SHALL NOT raise rvalid.
- A read of the same address granted at edge N+1 SHALL return the new data.
REQ-013 Back-to-back grants SHALL sustain one access per cycle, alternating ports under continuous dual requests: 0,1,0,1...
REQ-014 rdata SHALL hold its last value while no rvalid is asserted; requesters sample it only on their own rvalid.

Reset
REQ-015 rst_n=0 SHALL asynchronously force state IDLE, LAST=1 (port 0 wins first), and rvalid0=rvalid1=0.
REQ-016 During reset, gnt0=gnt1=0 and memory we=0; memory contents SHALL be preserved.
REQ-017 A read granted at the edge before reset asserts SHALL produce no rvalid after reset.

Structure
REQ-018 Shared package SHALL hold the FSM state encoding (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2) and the port index constants.
REQ-019 SHALL contain exactly one sub-module: the existing memory block, instantiated with FILE_NAME, ADDR_WIDTH and DATA_WIDTH.
REQ-020 RTL SHALL be 120-400 lines.

Verification
REQ-021 Single write then read: port0 writes 0xBEEF to addr 5, then reads addr 5 -> gnt0 each cycle, rvalid0=1 one cycle after the read, rdata=0xBEEF.
REQ-022 Contention after reset: req0=req1=1 (reads of addr 1 and addr 2) for 4 cycles -> grants 0,1,0,1; rvalid alternates, each one cycle later with the correct data.
REQ-023 Lock: port1 locks for 3 reads while req0=1 -> gnt1 for 3 cycles, gnt0 denied; gnt0 on the cycle after lock1 drops.
REQ-024 Write-then-read across ports: port0 writes 0x1234 to addr 63, then port1 reads addr 63 -> rvalid1 with rdata=0x1234.
REQ-025 Mid-operation reset: rst_n pulled low after a granted read, before its rvalid -> rvalid0/1 stay 0; after release, a dual request grants port 0 first.
REQ-026 Idle: no requests for 10 cycles -> memory we=0, no rvalid, rdata unchanged.
